// File: rtl/alu_seq_pkg.sv
// Shared types and ALU command encodings for the multi-byte ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_SHR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SHL  = 4'b0001;
    localparam logic [3:0] ALU_SHR  = 4'b0010;
    localparam logic [3:0] ALU_PASS = 4'b0111;

endpackage

// File: rtl/alu_mb_seq.sv
// Multi-byte sequencer: runs an NBYTES-wide add/sub/shift through an 8-bit ALU one byte per clock.
// Optional macro MBSEQ_CHAIN_EN: initial carry comes from cin (inverted for SUB as borrow-in).
module alu_mb_seq
    import alu_seq_pkg::*;
#(
    parameter int NBYTES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [8*NBYTES-1:0]   opA,
    input  logic [8*NBYTES-1:0]   opB,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  carry_out,
    output logic                  zero,
    output logic [3:0]            alu_cmd,
    output logic [7:0]            alu_inA,
    output logic [7:0]            alu_inB,
    output logic                  alu_sc_in,
    input  logic [7:0]            alu_rslt,
    input  logic                  alu_sc_o
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES - 1);

    function automatic logic [7:0] get_byte(input logic [W-1:0] v, input logic [IW-1:0] i);
        return v[8*int'(i) +: 8];
    endfunction

    function automatic logic [W-1:0] put_byte(input logic [W-1:0] v, input logic [IW-1:0] i,
                                              input logic [7:0] b);
        logic [W-1:0] r;
        r = v;
        r[8*int'(i) +: 8] = b;
        return r;
    endfunction

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   work_q, work_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_out_q, carry_out_d;
    logic           zero_q, zero_d;

    op_t            op_in;
    logic           init_carry;
    logic [W-1:0]   assembled;
    logic           last_byte;

    assign op_in = op_t'(op);

`ifdef MBSEQ_CHAIN_EN
    assign init_carry = (op_in == OP_SUB) ? ~cin : cin;
`else
    logic unused_cin;
    assign unused_cin = cin;
    // Only SUB starts with a carry (A + ~B + 1).
    assign init_carry = (op_in == OP_SUB);
`endif

    assign assembled = put_byte(work_q, idx_q, alu_rslt);
    assign last_byte = (op_q == OP_SHR) ? (idx_q == '0) : (idx_q == IDX_LAST);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        work_d      = work_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    op_d    = op_in;
                    a_d     = opA;
                    b_d     = opB;
                    idx_d   = (op_in == OP_SHR) ? IDX_LAST : '0;
                    carry_d = init_carry;
                end
            end
            S_RUN: begin
                work_d  = assembled;
                carry_d = alu_sc_o;
                idx_d   = (op_q == OP_SHR) ? idx_q - IW'(1) : idx_q + IW'(1);
                if (last_byte) begin
                    state_d     = S_DONE;
                    result_d    = assembled;
                    carry_out_d = alu_sc_o;
                    zero_d      = (assembled == '0);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            work_q      <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            work_q      <= work_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
        end
    end

    always_comb begin
        alu_cmd   = ALU_PASS;
        alu_inA   = '0;
        alu_inB   = '0;
        alu_sc_in = 1'b0;
        if (state_q == S_RUN) begin
            alu_inA   = get_byte(a_q, idx_q);
            alu_sc_in = carry_q;
            case (op_q)
                OP_ADD: begin
                    alu_cmd = ALU_ADD;
                    alu_inB = get_byte(b_q, idx_q);
                end
                OP_SUB: begin
                    alu_cmd = ALU_ADD;
                    alu_inB = ~get_byte(b_q, idx_q);
                end
                OP_SHL:  alu_cmd = ALU_SHL;
                OP_SHR:  alu_cmd = ALU_SHR;
                default: alu_cmd = ALU_PASS;
            endcase
        end
    end

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_mb_seq.sv
// Self-checking bench for alu_mb_seq with a behavioural 8-bit ALU wired to its alu_* ports.
module tb_alu_mb_seq;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  opA, opB;
    logic          cin;
    logic          busy, done, carry_out, zero;
    logic [W-1:0]  result;
    logic [3:0]    alu_cmd;
    logic [7:0]    alu_inA, alu_inB, alu_rslt;
    logic          alu_sc_in, alu_sc_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_mb_seq #(.NBYTES(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB), .cin(cin),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out), .zero(zero),
        .alu_cmd(alu_cmd), .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_sc_in(alu_sc_in),
        .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o)
    );

    // 8-bit ALU: add with carry, shift left/right through sc, pass A.
    always_comb begin
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            4'b0000: {alu_sc_o, alu_rslt} = {1'b0, alu_inA} + {1'b0, alu_inB} + {8'h00, alu_sc_in};
            4'b0001: {alu_sc_o, alu_rslt} = {alu_inA, alu_sc_in};
            4'b0010: begin
                alu_rslt = {alu_sc_in, alu_inA[7:1]};
                alu_sc_o = alu_inA[0];
            end
            4'b0111: alu_rslt = alu_inA;
            default: ;
        endcase
    end

    // Whole-word reference: returns {carry, result}.
    function automatic logic [W:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic ic;
        ic = (o == 2'b01);
`ifdef MBSEQ_CHAIN_EN
        ic = (o == 2'b01) ? ~cin : cin;
`endif
        case (o)
            2'b00:   return {1'b0, a} + {1'b0, b} + (W+1)'(ic);
            2'b01:   return {1'b0, a} + {1'b0, ~b} + (W+1)'(ic);
            2'b10:   return {a, ic};
            default: return {a[0], ic, a[W-1:1]};
        endcase
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, output logic [W-1:0] r, output logic co,
                         output logic z, output int done_at, output int busy_cnt);
        op = o; opA = a; opB = b; cin = c; start = 1'b1;
        done_at = -1; busy_cnt = 0; r = '0; co = 1'b0; z = 1'b0;
        for (int k = 1; k <= NB + 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (done && done_at < 0) begin
                done_at = k; r = result; co = carry_out; z = zero;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (result !== '0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
        checks++; if (carry_out !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry_out); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (alu_cmd !== 4'b0111) begin failures++; $display("FAIL idle_cmd got=%b exp=0111", alu_cmd); end
    endtask

    task automatic test_directed();
        logic [W-1:0] r; logic co, z; int d, bc;
        do_op(2'b00, 16'h12FF, 16'h0001, 1'b0, r, co, z, d, bc);
        checks++; if (r !== 16'h1300 || co !== 1'b0 || z !== 1'b0) begin failures++;
            $display("FAIL add1 got=%h/%b/%b exp=1300/0/0", r, co, z); end
        checks++; if (d !== NB + 1) begin failures++; $display("FAIL add1_done_cycle got=%0d exp=%0d", d, NB + 1); end
        checks++; if (bc !== NB) begin failures++; $display("FAIL add1_busy_cycles got=%0d exp=%0d", bc, NB); end
        do_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, r, co, z, d, bc);
        checks++; if (r !== 16'h0000 || co !== 1'b1 || z !== 1'b1) begin failures++;
            $display("FAIL add_wrap got=%h/%b/%b exp=0000/1/1", r, co, z); end
        do_op(2'b01, 16'h1000, 16'h0001, 1'b0, r, co, z, d, bc);
        checks++; if (r !== 16'h0FFF || co !== 1'b1) begin failures++;
            $display("FAIL sub1 got=%h/%b exp=0fff/1", r, co); end
        do_op(2'b01, 16'h0000, 16'h0001, 1'b0, r, co, z, d, bc);
        checks++; if (r !== 16'hFFFF || co !== 1'b0) begin failures++;
            $display("FAIL sub_borrow got=%h/%b exp=ffff/0", r, co); end
        do_op(2'b10, 16'h80C1, 16'h0000, 1'b0, r, co, z, d, bc);
        checks++; if (r !== 16'h0182 || co !== 1'b1) begin failures++;
            $display("FAIL shl got=%h/%b exp=0182/1", r, co); end
    endtask

    task automatic test_shr_drive();
        op = 2'b11; opA = 16'h0181; opB = 16'hFFFF; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++; if (alu_inA !== 8'h01 || alu_cmd !== 4'b0010) begin failures++;
            $display("FAIL shr_byte0 got=%h/%b exp=01/0010", alu_inA, alu_cmd); end
        @(posedge clk); #1;
        checks++; if (alu_inA !== 8'h81) begin failures++; $display("FAIL shr_byte1 got=%h exp=81", alu_inA); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b1 || result !== 16'h00C0 || carry_out !== 1'b1) begin failures++;
            $display("FAIL shr_result got=%b/%h/%b exp=1/00c0/1", done, result, carry_out); end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W-1:0] r, a, b; logic co, z, c; logic [1:0] o; logic [W:0] e; int d, bc;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3)); a = W'($urandom); b = W'($urandom); c = 1'($urandom_range(0, 1));
            if (n % 8 == 0) b = a;
            cin = c;
            e = model(o, a, b);
            do_op(o, a, b, c, r, co, z, d, bc);
            checks++; if (r !== e[W-1:0] || co !== e[W] || z !== (e[W-1:0] == '0) || d !== NB + 1) begin
                failures++;
                $display("FAIL rand_%0d op=%b a=%h b=%h got=%h/%b/%b@%0d exp=%h/%b/%b@%0d",
                         n, o, a, b, r, co, z, d, e[W-1:0], e[W], (e[W-1:0] == '0), NB + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, a2, b1; logic [W:0] e1, e2; logic [W-1:0] res [2]; int nd;
        logic b_idle, b_run;
        a1 = 16'h3456; a2 = 16'h9ABC; b1 = 16'h1111; cin = 1'b0;
        e1 = model(2'b00, a1, b1); e2 = model(2'b00, a2, b1);
        op = 2'b00; opA = a1; opB = b1; start = 1'b1; nd = 0; b_idle = 1'b1; b_run = 1'b0;
        res[0] = '0; res[1] = '0;
        for (int k = 1; k <= 2 * NB + 6; k++) begin
            @(posedge clk); #1;
            if (k == 1) opA = a2;
            if (done) begin
                if (nd < 2) res[nd] = result;
                nd++;
            end
            if (k == NB + 2) b_idle = busy;
            if (k == NB + 3) b_run = busy;
            if (k == 2 * NB + 3) start = 1'b0;
        end
        checks++; if (nd !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", nd); end
        checks++; if (b_idle !== 1'b0 || b_run !== 1'b1) begin failures++;
            $display("FAIL b2b_restart got=%b%b exp=01", b_idle, b_run); end
        checks++; if (res[0] !== e1[W-1:0]) begin failures++;
            $display("FAIL b2b_first got=%h exp=%h", res[0], e1[W-1:0]); end
        checks++; if (res[1] !== e2[W-1:0]) begin failures++;
            $display("FAIL b2b_second got=%h exp=%h", res[1], e2[W-1:0]); end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] r; logic co, z; int d, bc, nd;
        do_op(2'b00, 16'h1234, 16'h1111, 1'b0, r, co, z, d, bc);
        checks++; if (r !== 16'h2345) begin failures++; $display("FAIL abort_pre got=%h exp=2345", r); end
        op = 2'b00; opA = 16'h00FF; opB = 16'h0001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || zero !== 1'b1 || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_state got=%b/%b/%h/%b/%b exp=0/0/0000/1/0", busy, done, result, zero, carry_out);
        end
        nd = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        checks++; if (nd !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", nd); end
    endtask

    task automatic test_chain();
        logic [W-1:0] r, exp_r; logic co, z; int d, bc;
`ifdef MBSEQ_CHAIN_EN
        exp_r = 16'h0100;
`else
        exp_r = 16'h00FF;
`endif
        do_op(2'b00, 16'h00FF, 16'h0000, 1'b1, r, co, z, d, bc);
        checks++; if (r !== exp_r) begin failures++; $display("FAIL chain_cin got=%h exp=%h", r, exp_r); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_shr_drive();
        test_random();
        test_back_to_back();
        test_reset_abort();
        test_chain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
